// File: rtl/coefficient_responder_if.sv
// Coefficient-load bus between the loader (master) and the responder (slave).
interface coefficient_responder_if;
    logic        load_coeff;
    logic [1:0]  coefficient_num;
    logic [15:0] fir_coefficient;
    logic        clear_coeff;
    logic        modwait;
    logic [15:0] f0_coeff;
    logic [15:0] f1_coeff;
    logic [15:0] f2_coeff;
    logic [15:0] f3_coeff;
    logic [3:0]  coeff_valid;
    logic        all_loaded;
    logic        load_err;

    modport master (
        output load_coeff, coefficient_num, fir_coefficient, clear_coeff,
        input  modwait, f0_coeff, f1_coeff, f2_coeff, f3_coeff, coeff_valid, all_loaded,
               load_err
    );

    modport slave (
        input  load_coeff, coefficient_num, fir_coefficient, clear_coeff,
        output modwait, f0_coeff, f1_coeff, f2_coeff, f3_coeff, coeff_valid, all_loaded,
               load_err
    );
endinterface

// File: rtl/coefficient_responder.sv
// Responder for the coefficient-load handshake: latches a request, holds modwait for
// LOAD_CYCLES cycles, then writes the coefficient into F0..F3 and marks it valid.
module coefficient_responder #(
    parameter int unsigned LOAD_CYCLES = 2
) (
    input logic                    clk,
    input logic                    n_reset,
    coefficient_responder_if.slave bus
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [3:0] CntInit = 4'(LOAD_CYCLES - 1);

    state_e      state_q;
    logic        first_q;   // set during the first BUSY edge, where a held request is its tail
    logic [3:0]  cnt_q;
    logic [1:0]  num_q;
    logic [15:0] data_q;
    logic        modwait_q;
    logic        err_q;
    logic [3:0]  valid_q;
    logic [15:0] f_q [4];

    // Handshake FSM with registered outputs; clear is applied before a completing write
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= StIdle;
            first_q   <= 1'b0;
            cnt_q     <= '0;
            num_q     <= '0;
            data_q    <= '0;
            modwait_q <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                f_q[i] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            if (bus.clear_coeff) begin
                valid_q <= '0;
            end
            case (state_q)
                StIdle: begin
                    if (bus.load_coeff) begin
                        num_q     <= bus.coefficient_num;
                        data_q    <= bus.fir_coefficient;
                        cnt_q     <= CntInit;
                        first_q   <= 1'b1;
                        modwait_q <= 1'b1;
                        state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    first_q <= 1'b0;
                    if (bus.load_coeff && !first_q) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        f_q[num_q]     <= data_q;
                        valid_q[num_q] <= 1'b1;
                        modwait_q      <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.modwait     = modwait_q;
    assign bus.load_err    = err_q;
    assign bus.f0_coeff    = f_q[0];
    assign bus.f1_coeff    = f_q[1];
    assign bus.f2_coeff    = f_q[2];
    assign bus.f3_coeff    = f_q[3];
    assign bus.coeff_valid = valid_q;
    assign bus.all_loaded  = &valid_q;

endmodule

// File: tb/tb_coefficient_responder.sv
// Self-checking bench for coefficient_responder: directed scenarios plus random loads,
// compared against a cycle-level model of the load protocol.
module tb_coefficient_responder;

    localparam int unsigned LC = 2;

    logic clk = 1'b0;
    logic n_reset;

    coefficient_responder_if bus ();

    coefficient_responder #(.LOAD_CYCLES(LC)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_f [4];
    logic [3:0]  m_valid;
    logic        m_modwait;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_f[i] = 16'h0000;
        m_valid   = 4'b0000;
        m_modwait = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".modwait"},    32'(bus.modwait),     32'(m_modwait));
        chk({tag, ".load_err"},   32'(bus.load_err),    32'(m_err));
        chk({tag, ".f0"},         32'(bus.f0_coeff),    32'(m_f[0]));
        chk({tag, ".f1"},         32'(bus.f1_coeff),    32'(m_f[1]));
        chk({tag, ".f2"},         32'(bus.f2_coeff),    32'(m_f[2]));
        chk({tag, ".f3"},         32'(bus.f3_coeff),    32'(m_f[3]));
        chk({tag, ".valid"},      32'(bus.coeff_valid), 32'(m_valid));
        chk({tag, ".all_loaded"}, 32'(bus.all_loaded),  32'(m_valid == 4'b1111));
    endtask

    // One load transaction, starting just after a falling edge. tail holds the request
    // over the first busy edge; viol raises a second request (num 1, AAAA) on the last
    // busy edge; clr asserts clear_coeff on the completing edge.
    task automatic load_item(input logic [1:0] num, input logic [15:0] data,
                             input bit tail, input bit viol, input bit clr);
        logic ld;
        bus.load_coeff      = 1'b1;
        bus.coefficient_num = num;
        bus.fir_coefficient = data;
        bus.clear_coeff     = 1'b0;
        @(negedge clk);
        m_modwait = 1'b1;
        m_err     = 1'b0;
        check_all("accept");
        for (int k = 1; k <= int'(LC); k++) begin
            ld = (k == 1 && tail) || (k == int'(LC) && viol && k >= 2);
            bus.load_coeff      = ld;
            bus.coefficient_num = viol ? 2'd1 : 2'($urandom);
            bus.fir_coefficient = viol ? 16'hAAAA : 16'($urandom);
            bus.clear_coeff     = (k == int'(LC)) && clr;
            @(negedge clk);
            m_err = ld && (k >= 2);
            if (k == int'(LC)) begin
                if (clr) m_valid = 4'b0000;
                m_f[num]     = data;
                m_valid[num] = 1'b1;
                m_modwait    = 1'b0;
                check_all("write");
            end else begin
                check_all("busy");
            end
        end
        bus.load_coeff  = 1'b0;
        bus.clear_coeff = 1'b0;
        @(negedge clk);
        m_err = 1'b0;
        check_all("idle");
    endtask

    task automatic idle_step(input bit clr);
        bus.load_coeff  = 1'b0;
        bus.clear_coeff = clr;
        @(negedge clk);
        if (clr) m_valid = 4'b0000;
        m_err = 1'b0;
        check_all(clr ? "idle_clear" : "idle_gap");
        bus.clear_coeff = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load_coeff      = 1'b0;
        bus.coefficient_num = 2'd0;
        bus.fir_coefficient = 16'h0000;
        bus.clear_coeff     = 1'b0;
        n_reset             = 1'b1;

        // Asynchronous reset with no clock edge
        #2 n_reset = 1'b0;
        #1 model_reset();
        check_all("reset_async");
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all("reset_release");

        // Single load
        load_item(2'd2, 16'h8000, 1'b0, 1'b0, 1'b0);

        // Full set
        load_item(2'd0, 16'h0001, 1'b0, 1'b0, 1'b0);
        load_item(2'd1, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        load_item(2'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        load_item(2'd3, 16'h1234, 1'b0, 1'b0, 1'b0);
        chk("full_set.all_loaded", 32'(bus.all_loaded), 32'd1);

        // Protocol violation on the second busy edge
        load_item(2'd3, 16'h0F0F, 1'b0, 1'b1, 1'b0);

        // Clear colliding with a completing write
        load_item(2'd3, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        chk("collision.valid", 32'(bus.coeff_valid), 32'h8);

        // Request held over the first busy edge is silently ignored
        load_item(2'd1, 16'h1111, 1'b1, 1'b0, 1'b0);

        // Random traffic
        repeat (40) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_step(1'b1);
            end else begin
                load_item(2'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 5) == 0));
            end
            repeat ($urandom_range(0, 2)) idle_step(1'b0);
        end

        // Reset during a busy load of 5555 to F0
        bus.load_coeff      = 1'b1;
        bus.coefficient_num = 2'd0;
        bus.fir_coefficient = 16'h5555;
        @(negedge clk);
        bus.load_coeff = 1'b0;
        chk("midload.modwait_before", 32'(bus.modwait), 32'd1);
        #2 n_reset = 1'b0;
        #1 model_reset();
        check_all("reset_midload");
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check_all("after_midload_reset");
        load_item(2'd0, 16'h5555, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coefficient_responder.md
# coefficient_responder

Responder side of the coefficient-load handshake: accepts `load_coeff`/`coefficient_num` requests from the coefficient loader and answers with `modwait`. It stores each 16-bit coefficient into one of four registers (F0..F3) that feed the FIR datapath. It also tracks which coefficients are valid and flags load-protocol violations.

## Interface
- `LOAD_CYCLES`, default 2: cycles `modwait` stays high per load; legal range 1..15.
- `clk` in 1: system clock, all state updates on rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `load_coeff` in 1: load request (level; loader holds it until it observes `modwait`).
- `coefficient_num` in 2: target register index, valid while `load_coeff`=1.
- `fir_coefficient` in 16: coefficient value, valid while `load_coeff`=1.
- `clear_coeff` in 1: synchronous clear of valid flags.
- `modwait` out 1: busy/acknowledge, registered.
- `f0_coeff`, `f1_coeff`, `f2_coeff`, `f3_coeff` out 16 each: stored coefficients, registered.
- `coeff_valid` out 4: bit i set once Fi has been written since last clear/reset.
- `all_loaded` out 1: `&coeff_valid`, combinational from registers.
- `load_err` out 1: one-cycle pulse on protocol violation, registered.

## Operation
- Reset (async, n_reset=0): state IDLE, `modwait`=0, F0..F3=16'h0000, `coeff_valid`=4'b0000, `all_loaded`=0, `load_err`=0, holding regs and counter cleared.
- States:
  - IDLE: `modwait`=0. On an edge with `load_coeff`=1:
    - capture `coefficient_num` and `fir_coefficient` into holding regs;
    - set counter=`LOAD_CYCLES`-1;
    - set `modwait`=1;
    - go to BUSY.
  - BUSY: `modwait`=1. On each edge:
    - if counter≠0: decrement the counter.
    - if counter=0: write holding value into F[holding num], set `coeff_valid`[num], clear `modwait`, go to IDLE.
- Overlap rule: `load_coeff`=1 on the first BUSY edge is the tail of the accepted request and is silently ignored.
- Protocol violation: `load_coeff`=1 on any later BUSY edge sets `load_err`=1 for exactly one cycle. The request is dropped, and the in-progress load is unaffected.
- Inputs are sampled only on the accepting IDLE edge. Later changes to `fir_coefficient` or `coefficient_num` do not affect the stored value.
- Rewriting an already-valid index overwrites the value; its valid bit stays 1.
- `clear_coeff`=1 clears all `coeff_valid` bits on that edge. F registers keep their values, and any load in progress continues.
  - If clear coincides with a completing write, clear applies first and the written index's bit ends at 1.
- With `LOAD_CYCLES`=1, BUSY lasts one cycle; the overlap rule still applies to that single edge.
- A reset during BUSY aborts the load: no register write, and all state returns to reset values.

## Timing
- Request sampled at edge E0 → `modwait`=1 after E0.
- Write occurs at edge E0+`LOAD_CYCLES`: F register, `coeff_valid` and `all_loaded` update, and `modwait`=0 after that edge.
- `modwait` is high for exactly `LOAD_CYCLES` cycles.
- Earliest next accept is edge E0+`LOAD_CYCLES`+1.
- Back-to-back throughput: one coefficient per `LOAD_CYCLES`+1 cycles minimum.
- `load_err` is asserted for the single cycle following the offending edge.
- No combinational path from any input to `modwait`, F outputs or `load_err`.

## Test plan
- Reset: assert `n_reset`=0 mid-cycle with no clock edge → all outputs 0 immediately. Release → outputs remain 0 with inputs idle.
- Single load, `LOAD_CYCLES`=2: `load_coeff`=1, num=2, data=16'h8000, held until `modwait` seen →
  - `modwait` high for exactly 2 cycles;
  - `f2_coeff`=16'h8000 and `coeff_valid`=4'b0100 after the write edge;
  - `load_err` stays 0.
- Full set: load F0..F3 = 16'h0001, 16'h7FFF, 16'hFFFF, 16'h1234 in sequence, with the loader waiting for `modwait` low each time →
  - all four values stored;
  - `all_loaded` rises after the 4th write edge.
- Violation: during BUSY, re-assert `load_coeff` on the 2nd BUSY edge with num=1, data=16'hAAAA →
  - one-cycle `load_err`;
  - `f1_coeff` unchanged;
  - original load completes on schedule.
- Clear/write collision: with `coeff_valid`=4'b1111, assert `clear_coeff` on the edge completing a write to F3 → `coeff_valid`=4'b1000, and F0..F2 values retained.
- Reset mid-load: drop `n_reset` during BUSY of a write of 16'h5555 to F0 → F0=0 and `modwait`=0 immediately. A subsequent normal load to F0 succeeds.
